// File: rtl/wb_arb_pkg.sv
// Shared types, bus widths and helpers for the Wishbone bus arbiter.
package wb_arb_pkg;

  localparam int WB_ADR_W    = 32;
  localparam int WB_DAT_W    = 32;
  localparam int WB_SEL_W    = 4;
  localparam int MAX_MASTERS = 4;
  localparam int IDX_W       = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Index of the set bit in a one-hot vector; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational winner selection: round-robin after the last owner, or
// lowest index first when FIXED_PRIORITY is set.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic [N_MASTERS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last,
  output logic [N_MASTERS-1:0] o_win,
  output logic                 o_valid
);

  // Walk candidates in priority order; the first one that requests wins.
  always_comb begin
    int v_cand;
    o_win   = '0;
    o_valid = 1'b0;
    v_cand  = 0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (FIXED_PRIORITY != 0) v_cand = k;
      else                     v_cand = (int'(i_last) + 1 + k) % N_MASTERS;
      for (int j = 0; j < N_MASTERS; j++) begin
        if (!o_valid && i_req[j] && (j == v_cand)) begin
          o_win[j] = 1'b1;
          o_valid  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Shares one Wishbone classic slave between N_MASTERS masters. The grant is
// held for the whole CYC burst; a watchdog answers ERR when the slave stalls.
//
// Handshake: a beat is offered while the owner holds CYC and STB; it completes
// in the cycle the slave raises ACK or ERR (or the watchdog fires). Responses
// are only meaningful with CYC and STB high and are otherwise dropped.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [N_MASTERS*WB_ADR_W-1:0]   m_wb_adr_i,
  input  logic [N_MASTERS*WB_DAT_W-1:0]   m_wb_dat_i,
  output logic [WB_DAT_W-1:0]             m_wb_dat_o,
  input  logic [N_MASTERS-1:0]            m_wb_we_i,
  input  logic [N_MASTERS*WB_SEL_W-1:0]   m_wb_sel_i,
  input  logic [N_MASTERS-1:0]            m_wb_stb_i,
  input  logic [N_MASTERS-1:0]            m_wb_cyc_i,
  output logic [N_MASTERS-1:0]            m_wb_ack_o,
  output logic [N_MASTERS-1:0]            m_wb_err_o,
  output logic [WB_ADR_W-1:0]             s_wb_adr_o,
  output logic [WB_DAT_W-1:0]             s_wb_dat_o,
  input  logic [WB_DAT_W-1:0]             s_wb_dat_i,
  output logic                            s_wb_we_o,
  output logic [WB_SEL_W-1:0]             s_wb_sel_o,
  output logic                            s_wb_stb_o,
  output logic                            s_wb_cyc_o,
  input  logic                            s_wb_ack_i,
  input  logic                            s_wb_err_i,
  output logic [N_MASTERS-1:0]            o_grant,
  output logic                            o_timeout,
  output arb_state_e                      o_state
);

  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               WDOG_EN = (TIMEOUT_CYCLES != 0);

  arb_state_e           r_state, w_state_nxt;
  logic [N_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0]     r_last, w_last_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;

  logic [N_MASTERS-1:0] w_win;
  logic                 w_win_valid;
  logic [WB_ADR_W-1:0]  w_own_adr;
  logic [WB_DAT_W-1:0]  w_own_dat;
  logic [WB_SEL_W-1:0]  w_own_sel;
  logic                 w_own_we;
  logic                 w_own_stb;
  logic                 w_own_cyc;
  logic                 w_fire;
  logic                 w_resp_ok;

  wb_rr_pick #(
    .N_MASTERS      (N_MASTERS),
    .FIXED_PRIORITY (FIXED_PRIORITY)
  ) u_pick (
    .i_req   (m_wb_cyc_i),
    .i_last  (r_last),
    .o_win   (w_win),
    .o_valid (w_win_valid)
  );

  // Select the owner's request signals; grant is zero when idle so all are zero.
  always_comb begin
    w_own_adr = '0;
    w_own_dat = '0;
    w_own_sel = '0;
    w_own_we  = 1'b0;
    w_own_stb = 1'b0;
    w_own_cyc = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (r_grant[k]) begin
        w_own_adr = m_wb_adr_i[k*WB_ADR_W +: WB_ADR_W];
        w_own_dat = m_wb_dat_i[k*WB_DAT_W +: WB_DAT_W];
        w_own_sel = m_wb_sel_i[k*WB_SEL_W +: WB_SEL_W];
        w_own_we  = m_wb_we_i[k];
        w_own_stb = m_wb_stb_i[k];
        w_own_cyc = m_wb_cyc_i[k];
      end
    end
  end

  // Watchdog fires only when the slave stays silent; a real response wins.
  assign w_fire    = WDOG_EN && w_own_cyc && w_own_stb && (r_cnt == TO_CNT) &&
                     !s_wb_ack_i && !s_wb_err_i && !i_reset;
  assign w_resp_ok = w_own_cyc && w_own_stb && !i_reset;

  assign s_wb_cyc_o = w_own_cyc;
  assign s_wb_stb_o = w_own_cyc && w_own_stb && !w_fire;
  assign s_wb_adr_o = w_own_adr;
  assign s_wb_dat_o = w_own_dat;
  assign s_wb_sel_o = w_own_sel;
  assign s_wb_we_o  = w_own_we;
  assign m_wb_dat_o = s_wb_dat_i;
  assign m_wb_ack_o = (w_resp_ok && s_wb_ack_i) ? r_grant : '0;
  assign m_wb_err_o = (w_resp_ok && (s_wb_err_i || w_fire)) ? r_grant : '0;
  assign o_timeout  = w_fire;
  assign o_grant    = r_grant;
  assign o_state    = r_state;

  // Next-state logic: arbitrate in IDLE, hold the owner and run the watchdog in BUSY.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_win_valid) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = w_win;
        end
      end
      ST_BUSY: begin
        if (!w_own_cyc) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_last_nxt  = onehot_to_idx(MAX_MASTERS'(r_grant));
          w_cnt_nxt   = '0;
        end else if (!WDOG_EN || !w_own_stb || s_wb_ack_i || s_wb_err_i || w_fire) begin
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State register with synchronous reset; master 0 wins the first round-robin pick.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= IDX_W'(N_MASTERS - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Shares one 32-bit Wishbone classic slave bus between N_MASTERS Wishbone masters.
- Master 0 is the AXIS-to-Wishbone host bridge. Master 1 is an on-chip sequencer (e.g. motor/ESC update engine).
- The grant is held for the whole CYC burst. Arbitration is round-robin or fixed-priority.
- A bus-timeout watchdog returns ERR when a slave never responds, so no master can hang the bus.

Parameters:
- N_MASTERS, 2, number of requesting masters (2..4 supported).
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = lowest index always wins.
- TIMEOUT_CYCLES, 255, STB cycles without ACK/ERR before a forced ERR; 0 disables the watchdog.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- m_wb_adr_i  in  N_MASTERS*32  master addresses; master k uses bits [32k+31:32k].
- m_wb_dat_i  in  N_MASTERS*32  master write data.
- m_wb_dat_o  out  32  read data, broadcast to all masters.
- m_wb_we_i  in  N_MASTERS  master write enables.
- m_wb_sel_i  in  N_MASTERS*4  master byte selects.
- m_wb_stb_i  in  N_MASTERS  master strobes.
- m_wb_cyc_i  in  N_MASTERS  master cycle requests.
- m_wb_ack_o  out  N_MASTERS  per-master acknowledge.
- m_wb_err_o  out  N_MASTERS  per-master error.
- s_wb_adr_o  out  32  slave address.
- s_wb_dat_o  out  32  slave write data.
- s_wb_dat_i  in  32  slave read data.
- s_wb_we_o  out  1  slave write enable.
- s_wb_sel_o  out  4  slave byte select.
- s_wb_stb_o  out  1  slave strobe.
- s_wb_cyc_o  out  1  slave cycle.
- s_wb_ack_i  in  1  slave acknowledge.
- s_wb_err_i  in  1  slave error.
- o_grant  out  N_MASTERS  one-hot current owner; all zero when idle.
- o_timeout  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset values:
  - state = IDLE; o_grant = 0; o_timeout = 0; timeout counter = 0.
  - last_grant = N_MASTERS-1, so master 0 wins the first round-robin arbitration.
  - All s_wb_* outputs and all m_wb_ack_o / m_wb_err_o = 0.
- Reset mid-burst: the slave CYC/STB drop in the cycle after i_reset is sampled. No ACK or ERR is forwarded.
- States: IDLE, BUSY.
- IDLE:
  - s_wb_cyc_o = s_wb_stb_o = 0.
  - If any m_wb_cyc_i bit is set, register the winner into o_grant and go to BUSY.
  - Arbitration latency is one clock: master CYC at edge t gives slave CYC visible after edge t+1.
- Winner selection:
  - Round-robin: first requester strictly after last_grant, wrapping modulo N_MASTERS.
  - Fixed priority: lowest requesting index.
- BUSY:
  - The granted master's adr/dat/we/sel/stb/cyc drive the slave combinationally.
  - s_wb_ack_i / s_wb_err_i are routed only to the granted master; all other ack/err bits are 0.
  - s_wb_dat_i passes through to m_wb_dat_o.
  - Non-granted masters' STB is ignored and they wait.
- Release:
  - When the granted m_wb_cyc_i deasserts, s_wb_cyc_o drops in the same cycle (combinational).
  - Next edge: state = IDLE, last_grant = owner, o_grant = 0.
  - A minimum of one idle cycle occurs between owners.
- Watchdog (TIMEOUT_CYCLES > 0):
  - Counter clears on entering BUSY, on any ACK/ERR, and whenever STB is low.
  - It increments each cycle STB is high with no ACK/ERR.
  - When the count equals TIMEOUT_CYCLES, for one cycle: m_wb_err_o[owner] = 1, s_wb_stb_o is forced to 0, o_timeout = 1, and the counter clears.
  - Grant is kept until the master drops CYC.
  - A slave ACK/ERR in the same cycle the watchdog fires takes precedence: the response is forwarded, no timeout is raised, and the counter clears.
- Granted master drops CYC in the same cycle the timeout fires: no ERR, no o_timeout pulse; go to IDLE.
- ACK/ERR arriving while in IDLE or with STB low are ignored and never forwarded.
- Pipelined/burst tags are unsupported; classic cycles only.

Decomposition:
- Package wb_arb_pkg holds:
  - the state enum;
  - WB_ADR_W = 32, WB_DAT_W = 32, WB_SEL_W = 4;
  - a function one-hot to index.
- One sub-module, wb_rr_pick: combinational winner selection from the request vector, last_grant and FIXED_PRIORITY. It outputs a one-hot winner and a valid flag.
- The state register, watchdog and muxing stay in the top module.

Test Plan:
- Reset release, then master 0 writes 0xDEADBEEF to 0x40000010, slave ACKs on the 2nd STB cycle:
  - o_grant = 2'b01 one cycle after CYC;
  - slave sees the address and data;
  - m_wb_ack_o = 2'b01 for one cycle;
  - o_grant = 0 after CYC drops.
- Both masters assert CYC in the same cycle after reset, round-robin:
  - master 0 is granted first, then master 1, with exactly one idle cycle between;
  - master 1 never sees an ACK during master 0's burst.
- FIXED_PRIORITY = 1, master 0 re-requests immediately after each release while master 1 waits:
  - master 0 wins every time;
  - master 1 is granted once master 0 stays idle.
- TIMEOUT_CYCLES = 4, master 1 reads with no slave response:
  - m_wb_err_o = 2'b10 and o_timeout = 1 in the same cycle, on the 5th STB-high cycle;
  - s_wb_stb_o = 0 that cycle;
  - after master 1 drops CYC: IDLE.
- Slave ACK in the exact cycle the count reaches 4:
  - ACK is forwarded;
  - no ERR, no o_timeout.
- i_reset asserted mid-burst while master 0 owns the bus:
  - s_wb_cyc_o = 0 and o_grant = 0 on the next cycle;
  - a subsequent master 1 request is granted normally.
